dmem_pipe_model: RTL and testbench

Parametrised, pipelined data-memory model behind the data cache. It accepts one request per cycle with no blocking while requests are in flight, and applies byte-masked writes through the DPI memory hooks `read_mem`/`write_mem`. It returns whole cache lines in request order after a fixed latency, with a tag echo. Responses that the cache cannot take yet are buffered, and a credit scheme guarantees the buffer never overflows.

---
 rtl/tartaruga_pkg.sv | 51 +++++
 rtl/dmem_pipe_model_sync_fifo.sv | 51 +++++
 rtl/dmem_pipe_model.sv | 112 +++++++++++
 tb/tb_dmem_pipe_model.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types and memory hooks for the data-cache memory side.
// A simulation stub backs the memory hooks.
package tartaruga_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DMEM_WORDS     = 4;
  localparam int DMEM_ID_W      = 4;

  typedef struct packed {
    logic [31:0]                 addr;
    logic                        we;
    logic [BYTES_PER_WORD-1:0]   be;
    logic [31:0]                 wdata;
    logic [DMEM_ID_W-1:0]        id;
  } dmem_req_t;

  typedef struct packed {
    logic [31:0]                 addr;
    logic                        we;
    logic [DMEM_ID_W-1:0]        id;
    logic [32*DMEM_WORDS-1:0]    line;
  } dmem_rsp_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [BYTES_PER_WORD-1:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < BYTES_PER_WORD; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Sparse stub: unwritten words read back as their own address; last write is logged.
  logic [31:0] stub_mem [logic [31:0]];
  logic [31:0] wr_log_addr;
  logic [31:0] wr_log_data;
  int unsigned wr_log_n;

  function automatic logic [31:0] read_mem(input logic [31:0] addr);
    return stub_mem.exists(addr) ? stub_mem[addr] : addr;
  endfunction

  function automatic void write_mem(input logic [31:0] addr, input logic [31:0] data);
    stub_mem[addr] = data;
    wr_log_addr    = addr;
    wr_log_data    = data;
    wr_log_n       = wr_log_n + 1;
  endfunction

endpackage

// File: rtl/dmem_pipe_model_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;
  localparam int CW    = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [SLOTS];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_pipe_model.sv
// Pipelined data-memory model: byte-masked write then line read at accept,
// fixed-latency delay line, credit-protected response FIFO, in-order responses.
module dmem_pipe_model
  import tartaruga_pkg::*;
#(
  parameter int LAT   = 5,
  parameter int WORDS = 4,
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_be_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [ID_W-1:0]       req_id_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_addr_o,
  output logic [32*WORDS-1:0]   rsp_line_o,
  output logic                  rsp_we_o,
  output logic [ID_W-1:0]       rsp_id_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = 32*WORDS;

  typedef struct packed {
    logic [31:0]     addr;
    logic            we;
    logic [ID_W-1:0] id;
    logic [LW-1:0]   line;
  } rsp_t;
  localparam int RW = $bits(rsp_t);

  logic [CW-1:0]  cnt;
  logic           accept, pop;
  logic [LAT-1:0] vld_pipe;
  rsp_t           dat_pipe [LAT];
  rsp_t           head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [31:0]    line_base, word_addr;

  // Ready looks only at the registered credit count, never at a same-cycle pop.
  assign req_ready_o = (cnt < CW'(DEPTH));
  assign accept      = req_valid_i && req_ready_o && !rst_i;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign line_base   = req_addr_i & ~32'(4*WORDS-1);
  assign word_addr   = req_addr_i & ~32'd3;

  always_ff @(posedge clk_i) begin
    if (rst_i)                cnt <= '0;
    else if (accept && !pop)  cnt <= cnt + CW'(1);
    else if (pop && !accept)  cnt <= cnt - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int s = 1; s < LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Write lands in memory before the line is read, so the line reflects it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (req_we_i && (req_be_i != '0))
        write_mem(word_addr, merge_bytes(read_mem(word_addr), req_wdata_i, req_be_i));
      dat_pipe[0].addr <= line_base;
      dat_pipe[0].we   <= req_we_i;
      dat_pipe[0].id   <= req_id_i;
      for (int w = 0; w < WORDS; w++)
        dat_pipe[0].line[32*w +: 32] <= read_mem(line_base + 32'(4*w));
    end
    for (int s = 1; s < LAT; s++) dat_pipe[s] <= dat_pipe[s-1];
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (vld_pipe[LAT-1]),
    .pop   (pop),
    .wdata (dat_pipe[LAT-1]),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_addr_o  = rsp_valid_o ? head.addr : '0;
  assign rsp_line_o  = rsp_valid_o ? head.line : '0;
  assign rsp_we_o    = rsp_valid_o ? head.we   : 1'b0;
  assign rsp_id_o    = rsp_valid_o ? head.id   : '0;

  // Credits guarantee the FIFO has room whenever the delay line delivers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(fifo_full && vld_pipe[LAT-1]));
      assert (fifo_count <= cnt);
    end
  end

endmodule

// File: tb/tb_dmem_pipe_model.sv
// Bench: queue-based reference model checked every cycle, plus directed literal checks.
module tb_dmem_pipe_model;
  import tartaruga_pkg::*;

  localparam int LAT = 5, WORDS = 4, DEPTH = 4, ID_W = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic                req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we;
  logic [31:0]         req_addr, req_wdata, rsp_addr;
  logic [3:0]          req_be;
  logic [ID_W-1:0]     req_id, rsp_id;
  logic [32*WORDS-1:0] rsp_line;

  logic                s_valid, s_ready, s_rsp_valid, s_rsp_ready, s_rsp_we;
  logic [31:0]         s_addr, s_rsp_addr, s_rsp_line;
  logic [3:0]          s_id, s_rsp_id;

  dmem_pipe_model #(.LAT(LAT), .WORDS(WORDS), .DEPTH(DEPTH), .ID_W(ID_W)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_addr_o(rsp_addr),
    .rsp_line_o(rsp_line), .rsp_we_o(rsp_we), .rsp_id_o(rsp_id)
  );

  dmem_pipe_model #(.LAT(1), .WORDS(1), .DEPTH(1), .ID_W(4)) u_sweep (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(s_valid), .req_ready_o(s_ready), .req_addr_i(s_addr),
    .req_we_i(1'b0), .req_be_i(4'b0), .req_wdata_i(32'h0), .req_id_i(s_id),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(s_rsp_ready), .rsp_addr_o(s_rsp_addr),
    .rsp_line_o(s_rsp_line), .rsp_we_o(s_rsp_we), .rsp_id_o(s_rsp_id)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: memory map, credit count and a queue of pending responses,
  // each entry due LAT edges after its accept edge.
  typedef struct {
    int                  due;
    logic [31:0]         addr;
    logic                we;
    logic [ID_W-1:0]     id;
    logic [32*WORDS-1:0] line;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mm [logic [31:0]];
  int          cyc = 0, m_cnt = 0;
  bit          chk_en = 0;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : a;
  endfunction

  initial forever begin
    exp_t        e;
    logic [31:0] base, wa, m;
    bit          acc, pp;
    @(posedge clk_i);
    if (rst_i) begin
      mq.delete();
      m_cnt  = 0;
      chk_en = 1;
    end else begin
      acc = req_valid && (m_cnt < DEPTH);
      pp  = (mq.size() > 0) && (mq[0].due < cyc) && rsp_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        wa   = req_addr - (req_addr % 4);
        base = req_addr - (req_addr % (4*WORDS));
        if (req_we && req_be != 4'b0) begin
          m = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
          mm[wa] = (mrd(wa) & ~m) | (req_wdata & m);
        end
        e.due  = cyc + LAT;
        e.addr = base;
        e.we   = req_we;
        e.id   = req_id;
        e.line = '0;
        for (int w = 0; w < WORDS; w++) e.line[32*w +: 32] = mrd(base + 32'(4*w));
        mq.push_back(e);
      end
      m_cnt = m_cnt + int'(acc) - int'(pp);
    end
    cyc++;
  end

  initial forever begin
    bit ev;
    @(negedge clk_i);
    if (chk_en) begin
      ev = (mq.size() > 0) && (mq[0].due < cyc);
      chk("rsp_valid", rsp_valid, ev);
      chk("req_ready", req_ready, m_cnt < DEPTH);
      if (ev) begin
        chk("rsp_addr", rsp_addr, mq[0].addr);
        chk("rsp_line", rsp_line, mq[0].line);
        chk("rsp_we",   rsp_we,   mq[0].we);
        chk("rsp_id",   rsp_id,   mq[0].id);
      end
    end
  end

  initial begin
    int          acc_n, nv, k;
    bit          rdy_drop;
    logic [15:0] seen;
    int unsigned n0;
    logic [5:0]  sr, sv;
    logic [31:0] sa2, sa5, sl2, sl5;
    logic [3:0]  si2, si5;

    rst_i = 1; req_valid = 0; req_addr = 0; req_we = 0; req_be = 0; req_wdata = 0; req_id = 0;
    rsp_ready = 1; s_valid = 0; s_addr = 0; s_id = 0; s_rsp_ready = 1;
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_addr",  rsp_addr, 0);
    chk("rst_rsp_line",  rsp_line, 0);
    chk("rst_rsp_we",    rsp_we, 0);
    chk("rst_rsp_id",    rsp_id, 0);
    chk("rst_sweep_ready", s_ready, 1);
    rst_i = 0;
    @(negedge clk_i);

    // single read
    req_valid = 1; req_addr = 32'h104; req_id = 4'd3;
    @(negedge clk_i);
    req_valid = 0;
    repeat (LAT-1) @(negedge clk_i);
    chk("t1_not_yet", rsp_valid, 0);
    @(negedge clk_i);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_addr",  rsp_addr, 32'h100);
    chk("t1_line",  rsp_line, 128'h0000010C_00000108_00000104_00000100);
    chk("t1_id",    rsp_id, 4'd3);
    chk("t1_we",    rsp_we, 0);
    @(negedge clk_i);

    // back-to-back reads
    rdy_drop = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_addr = 32'(16*i); req_id = 4'(8+i);
      if (!req_ready) rdy_drop = 1;
      @(negedge clk_i);
    end
    req_valid = 0;
    seen = 0; nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) begin seen = {seen[11:0], rsp_id}; nv++; end
      @(negedge clk_i);
    end
    chk("t2_ready_held", rdy_drop, 0);
    chk("t2_nrsp", nv, 4);
    chk("t2_ids", seen, 16'h89AB);

    // backpressure
    rsp_ready = 0; acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_addr = 32'h300 + 32'(16*i); req_id = 4'(i);
      if (req_ready) acc_n++;
      @(negedge clk_i);
    end
    chk("t3_accepts", acc_n, 4);
    chk("t3_ready_low", req_ready, 0);
    chk("t3_head_valid", rsp_valid, 1);
    chk("t3_head_id", rsp_id, 4'd0);
    rsp_ready = 1;
    @(negedge clk_i);
    chk("t3_after_pop_id", rsp_id, 4'd1);
    chk("t3_after_pop_ready", req_ready, 1);
    req_valid = 0;
    repeat (12) @(negedge clk_i);
    chk("t3_ready_back", req_ready, 1);
    chk("t3_drained", rsp_valid, 0);

    // byte-masked write
    write_mem(32'h200, 32'h11223344);
    mm[32'h200] = 32'h11223344;
    n0 = wr_log_n;
    req_valid = 1; req_we = 1; req_addr = 32'h200; req_wdata = 32'hAABBCCDD; req_be = 4'b0101; req_id = 4'd7;
    @(negedge clk_i);
    req_valid = 0; req_we = 0; req_be = 0;
    chk("t4_wr_addr",  wr_log_addr, 32'h200);
    chk("t4_wr_data",  wr_log_data, 32'h11BB33DD);
    chk("t4_wr_calls", wr_log_n - n0, 1);
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk_i);
    chk("t4_rsp_seen",  rsp_valid, 1);
    chk("t4_rsp_word0", rsp_line[31:0], 32'h11BB33DD);
    chk("t4_rsp_we",    rsp_we, 1);
    @(negedge clk_i);
    req_valid = 1; req_addr = 32'h200; req_id = 4'd8;
    @(negedge clk_i);
    req_valid = 0;
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk_i);
    chk("t4_rd_seen",  rsp_valid, 1);
    chk("t4_rd_word0", rsp_line[31:0], 32'h11BB33DD);
    @(negedge clk_i);
    n0 = wr_log_n;
    req_valid = 1; req_we = 1; req_addr = 32'h204; req_wdata = 32'hFFFFFFFF; req_be = 4'b0000; req_id = 4'd9;
    @(negedge clk_i);
    req_valid = 0; req_we = 0;
    chk("t4_be0_no_write", wr_log_n - n0, 0);
    for (k = 0; k < 20 && !rsp_valid; k++) @(negedge clk_i);
    chk("t4_be0_seen",  rsp_valid, 1);
    chk("t4_be0_word1", rsp_line[63:32], 32'h204);
    @(negedge clk_i);

    // reset mid-flight
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = 32'h400 + 32'(4*i); req_id = 4'(i);
      @(negedge clk_i);
    end
    req_valid = 0;
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    chk("t5_ready", req_ready, 1);
    chk("t5_valid", rsp_valid, 0);
    nv = 0;
    repeat (10) begin
      if (rsp_valid) nv++;
      @(negedge clk_i);
    end
    chk("t5_no_rsp", nv, 0);

    // LAT=1, WORDS=1, DEPTH=1: ready drops after each accept and returns after the pop edge
    for (int i = 0; i < 6; i++) begin
      s_valid = 1; s_addr = 32'h40 + 32'(4*i); s_id = 4'(i);
      sr[i] = s_ready; sv[i] = s_rsp_valid;
      if (i == 2) begin sa2 = s_rsp_addr; sl2 = s_rsp_line; si2 = s_rsp_id; end
      if (i == 5) begin sa5 = s_rsp_addr; sl5 = s_rsp_line; si5 = s_rsp_id; end
      @(negedge clk_i);
    end
    s_valid = 0;
    chk("sw_ready_pat", sr, 6'b001001);
    chk("sw_valid_pat", sv, 6'b100100);
    chk("sw_addr0", sa2, 32'h40);
    chk("sw_line0", sl2, 32'h40);
    chk("sw_id0",   si2, 4'd0);
    chk("sw_addr1", sa5, 32'h4C);
    chk("sw_line1", sl5, 32'h4C);
    chk("sw_id1",   si5, 4'd3);
    repeat (3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
